// File: rtl/pixel_fetch_pkg.sv
// rtl/pixel_fetch_pkg.sv - shared constants and FSM state type for the pixel fetch block
package pixel_fetch_pkg;

  localparam int IMG_W_DEF = 1080;
  localparam int IMG_H_DEF = 960;
  localparam int ADDR_W    = 20;
  localparam int COORD_W   = 12;
  localparam int OOB_CNT_W = 20;
  localparam int BG_COLOR  = 0;

  typedef enum logic {
    ST_FILL   = 1'b0,
    ST_STREAM = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/pixel_fetch_if.sv
// rtl/pixel_fetch_if.sv - coordinate, frame-buffer and pixel-stream signals of pixel_fetch
interface pixel_fetch_if import pixel_fetch_pkg::*; #(
  parameter int PIX_W = 12
) ();

  logic [COORD_W-1:0]   xIn;
  logic [COORD_W-1:0]   yIn;
  logic                 addr_vld;
  logic                 mem_ready;
  logic [ADDR_W-1:0]    mem_addr;
  logic                 mem_en;
  logic [PIX_W-1:0]     mem_dout;
  logic [PIX_W-1:0]     pix_tdata;
  logic                 pix_tvalid;
  logic                 pix_tready;
  logic                 pix_tuser;
  logic                 pix_tlast;
  logic [OOB_CNT_W-1:0] oob_count;

  modport slave (
    input  xIn, yIn, addr_vld, mem_dout, pix_tready,
    output mem_ready, mem_addr, mem_en, pix_tdata, pix_tvalid, pix_tuser, pix_tlast, oob_count
  );

  modport master (
    output xIn, yIn, addr_vld, mem_dout, pix_tready,
    input  mem_ready, mem_addr, mem_en, pix_tdata, pix_tvalid, pix_tuser, pix_tlast, oob_count
  );

endinterface

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - synchronous FIFO whose head lives in an output register
module sync_fifo #(
  parameter int WIDTH = 12,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   mem_cnt;

  logic pop;
  logic head_free;
  logic mem_empty;
  logic load_from_mem;
  logic bypass;
  logic mem_wr;

  // A push into an empty FIFO lands straight in the head register so the
  // output appears on the cycle after the write.
  assign pop           = rd_en & rd_valid;
  assign head_free     = ~rd_valid | pop;
  assign mem_empty     = (mem_cnt == '0);
  assign load_from_mem = head_free & ~mem_empty;
  assign bypass        = head_free & mem_empty & wr_en;
  assign mem_wr        = wr_en & ~bypass;

  always_ff @(posedge clk) begin
    if (!reset && mem_wr) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      mem_cnt  <= '0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      if (mem_wr) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (load_from_mem) begin
        rd_data <= mem[rd_ptr];
        rd_ptr  <= rd_ptr + PTR_W'(1);
      end else if (bypass) begin
        rd_data <= wr_data;
      end
      if (head_free) begin
        rd_valid <= load_from_mem | bypass;
      end
      case ({mem_wr, load_from_mem})
        2'b10:   mem_cnt <= mem_cnt + (PTR_W+1)'(1);
        2'b01:   mem_cnt <= mem_cnt - (PTR_W+1)'(1);
        default: mem_cnt <= mem_cnt;
      endcase
    end
  end

endmodule

// File: rtl/pixel_fetch.sv
// rtl/pixel_fetch.sv - coordinate to frame-buffer read and pixel stream with raster markers
// Optional per-frame out-of-bounds statistics: PIXEL_FETCH_OOB_STATS_EN.
module pixel_fetch import pixel_fetch_pkg::*; #(
  parameter int IMG_W      = IMG_W_DEF,
  parameter int IMG_H      = IMG_H_DEF,
  parameter int PIX_W      = 12,
  parameter int MEM_LAT    = 2,
  parameter int FIFO_DEPTH = 8
) (
  input  logic          clk,
  input  logic          reset,
  pixel_fetch_if.slave  bus
);

  localparam int CRED_W = $clog2(FIFO_DEPTH + 1);
  localparam int COL_W  = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int ROW_W  = (IMG_H > 1) ? $clog2(IMG_H) : 1;
`ifdef PIXEL_FETCH_OOB_STATS_EN
  localparam int FIFO_W = PIX_W + 1;
`else
  localparam int FIFO_W = PIX_W;
`endif

  logic              xfer;
  logic              in_oob;
  logic              pop;
  logic              push;
  logic [PIX_W-1:0]  push_pix;
  logic [FIFO_W-1:0] fifo_din;
  logic [FIFO_W-1:0] fifo_head;
  logic              head_vld;

  logic [ADDR_W-1:0] mem_addr_q;
  logic              mem_en_q;
  logic [MEM_LAT:0]  dl_vld;
  logic [MEM_LAT:0]  dl_oob;
  logic [CRED_W-1:0] credit;
  logic [COL_W-1:0]  col;
  logic [ROW_W-1:0]  row;
  logic              last_col;
  logic              last_row;

  fetch_state_e      state;
  fetch_state_e      state_nxt;
  logic              cnt_adv;

  assign xfer   = bus.addr_vld & bus.mem_ready;
  assign in_oob = (int'(bus.xIn) >= IMG_W) || (int'(bus.yIn) >= IMG_H);
  assign pop    = head_vld & bus.pix_tready;

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_addr_q <= '0;
      mem_en_q   <= 1'b0;
    end else begin
      mem_en_q <= xfer & ~in_oob;
      if (xfer && !in_oob) begin
        mem_addr_q <= ADDR_W'(int'(bus.yIn) * IMG_W + int'(bus.xIn));
      end
    end
  end

  assign bus.mem_addr = mem_addr_q;
  assign bus.mem_en   = mem_en_q;

  // Stage MEM_LAT of the delay line lines up with mem_dout for the same request.
  always_ff @(posedge clk) begin
    if (reset) begin
      dl_vld <= '0;
      dl_oob <= '0;
    end else begin
      dl_vld <= {dl_vld[MEM_LAT-1:0], xfer};
      dl_oob <= {dl_oob[MEM_LAT-1:0], xfer & in_oob};
    end
  end

  assign push     = dl_vld[MEM_LAT];
  assign push_pix = dl_oob[MEM_LAT] ? PIX_W'(BG_COLOR) : bus.mem_dout;
`ifdef PIXEL_FETCH_OOB_STATS_EN
  assign fifo_din = {dl_oob[MEM_LAT], push_pix};
`else
  assign fifo_din = push_pix;
`endif

  sync_fifo #(
    .WIDTH (FIFO_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (push),
    .wr_data  (fifo_din),
    .rd_en    (bus.pix_tready),
    .rd_data  (fifo_head),
    .rd_valid (head_vld)
  );

  // Credit covers both in-flight reads and buffered pixels, so the FIFO cannot overflow.
  always_ff @(posedge clk) begin
    if (reset) begin
      credit <= '0;
    end else begin
      case ({xfer, pop})
        2'b10:   credit <= credit + CRED_W'(1);
        2'b01:   credit <= credit - CRED_W'(1);
        default: credit <= credit;
      endcase
    end
  end

  assign bus.mem_ready = (credit < CRED_W'(FIFO_DEPTH));

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_FILL;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_adv   = 1'b0;
    unique case (state)
      ST_FILL: begin
        if (push) begin
          state_nxt = ST_STREAM;
        end
      end
      ST_STREAM: begin
        cnt_adv = pop;
      end
      default: state_nxt = ST_FILL;
    endcase
  end

  assign last_col = (col == COL_W'(IMG_W - 1));
  assign last_row = (row == ROW_W'(IMG_H - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      col <= '0;
      row <= '0;
    end else if (cnt_adv) begin
      if (last_col) begin
        col <= '0;
        row <= last_row ? '0 : row + ROW_W'(1);
      end else begin
        col <= col + COL_W'(1);
      end
    end
  end

  assign bus.pix_tdata  = fifo_head[PIX_W-1:0];
  assign bus.pix_tvalid = head_vld;
  assign bus.pix_tuser  = head_vld & (col == '0) & (row == '0);
  assign bus.pix_tlast  = head_vld & last_col;

`ifdef PIXEL_FETCH_OOB_STATS_EN
  logic                 head_oob;
  logic [OOB_CNT_W-1:0] oob_acc;
  logic [OOB_CNT_W-1:0] oob_acc_inc;
  logic [OOB_CNT_W-1:0] oob_total;

  assign head_oob    = fifo_head[PIX_W];
  assign oob_acc_inc = (head_oob && (oob_acc != '1)) ? oob_acc + OOB_CNT_W'(1) : oob_acc;

  always_ff @(posedge clk) begin
    if (reset) begin
      oob_acc   <= '0;
      oob_total <= '0;
    end else if (cnt_adv) begin
      if (last_col && last_row) begin
        oob_total <= oob_acc_inc;
        oob_acc   <= '0;
      end else begin
        oob_acc <= oob_acc_inc;
      end
    end
  end

  assign bus.oob_count = oob_total;
`else
  assign bus.oob_count = '0;
`endif

endmodule

// File: tb/tb_pixel_fetch.sv
// tb/tb_pixel_fetch.sv - directed and random checks of pixel_fetch against a queue-based model
module tb_pixel_fetch;
  import pixel_fetch_pkg::*;

  localparam int W     = 1080;
  localparam int H     = 4;
  localparam int LAT   = 2;
  localparam int DEPTH = 8;
  localparam int PW    = 12;
  localparam int FRAME = W * H;
`ifdef PIXEL_FETCH_OOB_STATS_EN
  localparam int OOB1_EXP = 2;
`else
  localparam int OOB1_EXP = 0;
`endif

  typedef struct {
    logic          oob;
    logic [PW-1:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  pixel_fetch_if #(.PIX_W(PW)) bus ();

  pixel_fetch #(
    .IMG_W(W), .IMG_H(H), .PIX_W(PW), .MEM_LAT(LAT), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  function automatic logic [PW-1:0] mem_word(input int a);
    return PW'((a * 37 + 11) % 4093 + 1);
  endfunction

  logic [PW-1:0] rd_pipe [LAT];
  always @(posedge clk) begin
    rd_pipe[0] <= bus.mem_en ? mem_word(int'(bus.mem_addr)) : 12'hBAD;
    for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign bus.mem_dout = rd_pipe[LAT-1];

  exp_t          sb[$];
  int            checks, failures;
  int            pix_n, oob_acc, exp_oob, xfer_count, exp_addr;
  logic          exp_en;
  logic          prev_stall, prev_user, prev_last;
  logic [PW-1:0] prev_data;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic monitor();
    exp_t e;
    logic oob;
    if (reset) begin
      sb.delete();
      pix_n = 0; oob_acc = 0; exp_oob = 0;
      prev_stall = 1'b0; exp_en = 1'b0;
    end else begin
      chk("oob_count", bus.oob_count, exp_oob);
      chk("mem_en", bus.mem_en, exp_en);
      if (exp_en) chk("mem_addr", bus.mem_addr, exp_addr);
      if (prev_stall) begin
        chk("stall_valid", bus.pix_tvalid, 1);
        chk("stall_tdata", bus.pix_tdata, prev_data);
        chk("stall_tuser", bus.pix_tuser, prev_user);
        chk("stall_tlast", bus.pix_tlast, prev_last);
      end
      if (bus.pix_tvalid && bus.pix_tready) begin
        if (sb.size() == 0) begin
          chk("unexpected_pixel", bus.pix_tvalid, 0);
        end else begin
          e = sb.pop_front();
          chk("pix_tdata", bus.pix_tdata, e.data);
          chk("pix_tuser", bus.pix_tuser, (pix_n % FRAME) == 0);
          chk("pix_tlast", bus.pix_tlast, (pix_n % W) == W - 1);
          if (e.oob) oob_acc++;
          if ((pix_n % FRAME) == FRAME - 1) begin
`ifdef PIXEL_FETCH_OOB_STATS_EN
            exp_oob = (oob_acc > 1048575) ? 1048575 : oob_acc;
`else
            exp_oob = 0;
`endif
            oob_acc = 0;
          end
          pix_n++;
        end
      end
      prev_stall = bus.pix_tvalid && !bus.pix_tready;
      prev_data  = bus.pix_tdata;
      prev_user  = bus.pix_tuser;
      prev_last  = bus.pix_tlast;
      exp_en = 1'b0;
      if (bus.addr_vld && bus.mem_ready) begin
        xfer_count++;
        oob = (int'(bus.xIn) >= W) || (int'(bus.yIn) >= H);
        exp_addr = int'(bus.yIn) * W + int'(bus.xIn);
        e.oob  = oob;
        e.data = oob ? PW'(0) : mem_word(exp_addr);
        sb.push_back(e);
        exp_en = !oob;
      end
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    bus.addr_vld = 1'b0;
    bus.pix_tready = 1'b1;
    for (int g = 0; g < 100 && sb.size() != 0; g++) cycle();
    chk("drain_empty", sb.size(), 0);
    chk("drain_tvalid", bus.pix_tvalid, 0);
  endtask

  initial begin
    checks = 0; failures = 0; xfer_count = 0;
    bus.addr_vld = 1'b0; bus.xIn = '0; bus.yIn = '0; bus.pix_tready = 1'b0;
    reset = 1'b1;
    repeat (3) cycle();
    reset = 1'b0;
    chk("rst_mem_ready", bus.mem_ready, 1);
    chk("rst_mem_en", bus.mem_en, 0);
    chk("rst_mem_addr", bus.mem_addr, 0);
    chk("rst_tvalid", bus.pix_tvalid, 0);
    chk("rst_tdata", bus.pix_tdata, 0);
    chk("rst_tuser", bus.pix_tuser, 0);
    chk("rst_tlast", bus.pix_tlast, 0);
    chk("rst_oob_count", bus.oob_count, 0);

    // single in-bounds fetch and its latency
    bus.pix_tready = 1'b1;
    bus.addr_vld = 1'b1; bus.xIn = 12'd5; bus.yIn = 12'd2;
    cycle();
    bus.addr_vld = 1'b0;
    chk("addr_en", bus.mem_en, 1);
    chk("addr_val", bus.mem_addr, 2165);
    cycle();
    chk("en_one_cycle", bus.mem_en, 0);
    chk("lat_early2", bus.pix_tvalid, 0);
    cycle();
    chk("lat_early3", bus.pix_tvalid, 0);
    cycle();
    chk("lat_valid", bus.pix_tvalid, 1);
    chk("lat_data", bus.pix_tdata, mem_word(2165));
    chk("lat_tuser", bus.pix_tuser, 1);

    // out-of-bounds coordinates
    bus.addr_vld = 1'b1; bus.xIn = 12'd1080; bus.yIn = 12'd0;
    cycle();
    chk("oob_x_en", bus.mem_en, 0);
    chk("oob_x_addr", bus.mem_addr, 2165);
    bus.xIn = 12'hFFF; bus.yIn = 12'd3;
    cycle();
    bus.addr_vld = 1'b0;
    chk("oob_wrap_en", bus.mem_en, 0);
    chk("oob_wrap_addr", bus.mem_addr, 2165);
    for (int g = 0; g < 20 && pix_n < 3; g++) cycle();
    chk("oob_popped", pix_n, 3);

    // rest of the first frame, in bounds at full rate
    bus.addr_vld = 1'b1;
    for (int g = 0; g < 20000 && xfer_count < FRAME; g++) begin
      bus.xIn = 12'($urandom_range(0, W - 1));
      bus.yIn = 12'($urandom_range(0, H - 1));
      cycle();
    end
    bus.addr_vld = 1'b0;
    for (int g = 0; g < 100 && pix_n < FRAME; g++) cycle();
    chk("frame1_done", pix_n, FRAME);
    cycle();
    chk("oob_frame1", bus.oob_count, OOB1_EXP);

    // backpressure: credit limits acceptance to the buffer depth
    bus.pix_tready = 1'b0; bus.addr_vld = 1'b1; xfer_count = 0;
    for (int g = 0; g < 20; g++) begin
      bus.xIn = 12'($urandom_range(0, W - 1));
      bus.yIn = 12'($urandom_range(0, H - 1));
      cycle();
    end
    chk("stall_accept", xfer_count, DEPTH);
    chk("stall_ready", bus.mem_ready, 0);
    bus.pix_tready = 1'b1;
    cycle();
    bus.pix_tready = 1'b0;
    for (int g = 0; g < 10; g++) cycle();
    chk("one_more_accept", xfer_count, DEPTH + 1);
    chk("stall_ready2", bus.mem_ready, 0);
    drain();

    // random traffic with random backpressure
    for (int g = 0; g < 4000; g++) begin
      bus.addr_vld = 1'($urandom % 2);
      bus.pix_tready = 1'($urandom % 2);
      bus.xIn = 12'($urandom_range(0, W + 40));
      bus.yIn = 12'($urandom_range(0, H));
      cycle();
    end
    drain();

    // complete the second frame with mixed in/out-of-bounds coordinates
    bus.addr_vld = 1'b1;
    for (int g = 0; g < 20000 && pix_n < 2 * FRAME; g++) begin
      bus.xIn = ($urandom % 16 == 0) ? 12'hFFF : 12'($urandom_range(0, W - 1));
      bus.yIn = 12'($urandom_range(0, H - 1));
      cycle();
    end
    drain();
    chk("frame2_done", (pix_n >= 2 * FRAME), 1);
    chk("oob_frame2", bus.oob_count, exp_oob);

    // reset with reads in flight
    bus.pix_tready = 1'b1; bus.addr_vld = 1'b1;
    for (int g = 0; g < 3; g++) begin
      bus.xIn = 12'(100 + g); bus.yIn = 12'd1;
      cycle();
    end
    bus.addr_vld = 1'b0;
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    for (int g = 0; g < 8; g++) begin
      chk("no_stale", bus.pix_tvalid, 0);
      cycle();
    end
    bus.addr_vld = 1'b1; bus.xIn = 12'd7; bus.yIn = 12'd1;
    cycle();
    bus.addr_vld = 1'b0;
    for (int g = 0; g < 10 && !bus.pix_tvalid; g++) cycle();
    chk("post_rst_valid", bus.pix_tvalid, 1);
    chk("post_rst_tuser", bus.pix_tuser, 1);
    chk("post_rst_data", bus.pix_tdata, mem_word(W + 7));
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
